// File: rtl/fifo_write_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fifo_write_arbiter_if                                            |
// | Brief   : Request/grant/write-strobe bundle between requesters, the FIFO   |
// |           status and fifo_write_arbiter. lock exists only with ARB_LOCK_EN.|
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface fifo_write_arbiter_if #(
  parameter int N = 4
);
  localparam int ID_W = $clog2(N);

  logic [N-1:0]    req;
  logic            fifo_full;
`ifdef ARB_LOCK_EN
  logic            lock;
`endif
  logic [N-1:0]    grant;
  logic [ID_W-1:0] grant_id;
  logic            write;
  logic            busy;

  modport master (
    output req,
    output fifo_full,
`ifdef ARB_LOCK_EN
    output lock,
`endif
    input  grant,
    input  grant_id,
    input  write,
    input  busy
  );

  modport slave (
    input  req,
    input  fifo_full,
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    output grant,
    output grant_id,
    output write,
    output busy
  );
endinterface : fifo_write_arbiter_if
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fifo_write_arbiter                                               |
// | Brief   : Round-robin owner of the single FIFO write port, bursts of up to |
// |           MAX_BURST beats. Optional burst lock under macro ARB_LOCK_EN.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fifo_write_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 4
) (
  input  wire logic           clk,
  input  wire logic           reset,
  fifo_write_arbiter_if.slave bus
);
  localparam int ID_W    = $clog2(N);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int SUM_W   = ID_W + 1;

  localparam logic [BURST_W-1:0] c_last = BURST_W'(MAX_BURST - 1);
  localparam logic [N-1:0]       c_one  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [N-1:0]       r_grant;
  logic [ID_W-1:0]    r_owner;
  logic [ID_W-1:0]    r_ptr;
  logic [BURST_W-1:0] r_burst_cnt;
  logic               r_busy;

  logic [ID_W-1:0]    w_base;
  logic [2*N-1:0]     w_req2;
  logic [N-1:0]       w_rot;
  logic [ID_W-1:0]    w_offset;
  logic [SUM_W-1:0]   w_sum;
  logic [ID_W-1:0]    w_winner;
  logic               w_hit;
  logic               w_owner_req;
  logic               w_write;
  logic               w_lock_hold;
  logic               w_last_beat;
  logic               w_release;

  // On release the search starts after the outgoing owner, so it is the same
  // base the pointer is about to take.
  assign w_base = (r_state == OWN) ? r_owner : r_ptr;

  // Rotating the doubled request vector puts requester (base+1) at bit 0.
  assign w_req2 = {bus.req, bus.req};
  assign w_rot  = N'(w_req2 >> ({1'b0, w_base} + SUM_W'(1)));

  always_comb begin
    w_hit    = |w_rot;
    w_offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_offset = ID_W'(i);
      end
    end
    w_sum = SUM_W'(w_base) + SUM_W'(w_offset) + SUM_W'(1);
    if (w_sum >= SUM_W'(N)) begin
      w_sum = w_sum - SUM_W'(N);
    end
    w_winner = w_sum[ID_W-1:0];
  end

  assign w_owner_req = bus.req[r_owner];
  assign w_write     = r_busy & w_owner_req & ~bus.fifo_full;

`ifdef ARB_LOCK_EN
  assign w_lock_hold = bus.lock & w_owner_req;
`else
  assign w_lock_hold = 1'b0;
`endif

  assign w_last_beat = w_write & (r_burst_cnt == c_last) & ~w_lock_hold;
  assign w_release   = ~w_owner_req | w_last_beat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_owner     <= '0;
      r_ptr       <= ID_W'(N - 1);
      r_burst_cnt <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_state     <= OWN;
            r_grant     <= c_one << w_winner;
            r_owner     <= w_winner;
            r_busy      <= 1'b1;
            r_burst_cnt <= '0;
          end
        end
        OWN: begin
          if (w_release) begin
            r_ptr       <= r_owner;
            r_burst_cnt <= '0;
            if (w_hit) begin
              r_grant <= c_one << w_winner;
              r_owner <= w_winner;
            end else begin
              r_state <= IDLE;
              r_grant <= '0;
              r_owner <= '0;
              r_busy  <= 1'b0;
            end
          end else if (w_write && (r_burst_cnt != c_last)) begin
            // Holding at the last value lets a locked burst run on indefinitely.
            r_burst_cnt <= r_burst_cnt + BURST_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant    = r_grant;
  assign bus.grant_id = r_owner;
  assign bus.write    = w_write;
  assign bus.busy     = r_busy;

endmodule : fifo_write_arbiter
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fifo_write_arbiter                                            |
// | Brief   : Directed bench; expected write beats queued per owner id.        |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_fifo_write_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int unsigned exp_q[$];

  fifo_write_arbiter_if #(.N(4)) bus ();

  fifo_write_arbiter #(.N(4), .MAX_BURST(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_n(input int unsigned id, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(id);
  endtask

  task automatic drive(input logic [3:0] r, input logic f);
    @(posedge clk);
    #1;
    bus.req       = r;
    bus.fifo_full = f;
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    bus.req       = '0;
    bus.fifo_full = 1'b0;
`ifdef ARB_LOCK_EN
    bus.lock      = 1'b0;
`endif
    @(posedge clk);
    #1;
    check("rst_grant", bus.grant, 0);
    check("rst_id", bus.grant_id, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_write", bus.write, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Scoreboard side: every write beat must match the next queued owner id.
  always @(negedge clk) begin
    logic [31:0] oh;
    oh = 32'd1 << bus.grant_id;
    if (bus.grant === 4'b0000) check("idle_id", bus.grant_id, 0);
    else check("onehot", bus.grant, oh);
    if (bus.write === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_write: observed write by id %0d, expected no write", bus.grant_id);
      end
      if (exp_q.size() > 0) check("beat_id", bus.grant_id, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ids[5] = '{0, 1, 2, 3, 0};

    // Single requester: a full burst, then regranted without a bubble.
    do_reset();
    bus.req = 4'b0001;
    push_n(0, 6);
    drive(4'b0001, 1'b0);
    check("t1_grant", bus.grant, 4'b0001);
    check("t1_busy", bus.busy, 1);
    #1 check("t1_write", bus.write, 1);
    repeat (3) drive(4'b0001, 1'b0);
    drive(4'b0001, 1'b0);
    check("t1_regrant", bus.grant, 4'b0001);
    check("t1_regrant_busy", bus.busy, 1);
    drive(4'b0001, 1'b0);
    drive(4'b0000, 1'b0);
    #1 check("t1_drop_write", bus.write, 0);
    drive(4'b0000, 1'b0);
    check("t1_idle_grant", bus.grant, 0);
    check("t1_idle_busy", bus.busy, 0);
    check("t1_q_empty", exp_q.size(), 0);

    // All requesting: 0,1,2,3,0 with four beats each.
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) push_n(ids[k], 4);
    for (int k = 1; k <= 20; k++) begin
      drive(4'b1111, 1'b0);
      if ((k - 1) % 4 == 0) begin
        check("t2_owner", bus.grant_id, ids[(k - 1) / 4]);
        check("t2_busy", bus.busy, 1);
      end
    end
    drive(4'b0000, 1'b0);
    check("t2_next_owner", bus.grant_id, 1);
    drive(4'b0000, 1'b0);
    check("t2_idle", bus.grant, 0);
    check("t2_q_empty", exp_q.size(), 0);

    // Owner 2 stalled by fifo_full, including on its last beat.
    bus.req = 4'b1100;
    push_n(2, 4);
    drive(4'b1100, 1'b0);
    check("t3_owner", bus.grant_id, 2);
    drive(4'b1100, 1'b0);
    drive(4'b1100, 1'b1);
    #1 check("t3_stall_write", bus.write, 0);
    drive(4'b1100, 1'b1);
    drive(4'b1100, 1'b1);
    check("t3_stall_grant", bus.grant, 4'b0100);
    drive(4'b1100, 1'b0);
    drive(4'b1100, 1'b1);
    drive(4'b1100, 1'b0);
    check("t3_last_stall_hold", bus.grant_id, 2);
    drive(4'b0000, 1'b0);
    check("t3_rotate", bus.grant_id, 3);
    drive(4'b0000, 1'b0);
    check("t3_idle", bus.grant, 0);
    check("t3_q_empty", exp_q.size(), 0);

    // Owner 1 drops after two beats; 3 then gets a full fresh burst.
    bus.req = 4'b1010;
    push_n(1, 2);
    push_n(3, 4);
    drive(4'b1010, 1'b0);
    check("t4_owner", bus.grant_id, 1);
    drive(4'b1010, 1'b0);
    drive(4'b1000, 1'b0);
    #1 check("t4_drop_write", bus.write, 0);
    drive(4'b1001, 1'b0);
    check("t4_handover_id", bus.grant_id, 3);
    check("t4_handover_grant", bus.grant, 4'b1000);
    repeat (3) drive(4'b1001, 1'b0);
    check("t4_full_burst", bus.grant_id, 3);
    drive(4'b0000, 1'b0);
    check("t4_rotate", bus.grant_id, 0);
    drive(4'b0000, 1'b0);
    check("t4_idle", bus.grant, 0);
    check("t4_q_empty", exp_q.size(), 0);

    // Async reset mid-burst drops the pending beat; 0 wins first after it.
    bus.req = 4'b0100;
    push_n(2, 2);
    drive(4'b0100, 1'b0);
    check("t5_owner", bus.grant_id, 2);
    drive(4'b0100, 1'b0);
    drive(4'b1111, 1'b0);
    #1 reset = 1'b0;
    #1;
    check("t5_async_grant", bus.grant, 0);
    check("t5_async_write", bus.write, 0);
    check("t5_async_busy", bus.busy, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(4'b0000, 1'b0);
    check("t5_first_grant", bus.grant, 4'b0001);
    check("t5_first_id", bus.grant_id, 0);
    drive(4'b0000, 1'b0);
    check("t5_idle", bus.grant, 0);
    check("t5_q_empty", exp_q.size(), 0);

`ifdef ARB_LOCK_EN
    // Locked burst runs past MAX_BURST, ends on the first beat after unlock.
    do_reset();
    bus.lock = 1'b1;
    bus.req  = 4'b1111;
    push_n(0, 7);
    repeat (5) drive(4'b1111, 1'b0);
    check("t6_locked_owner", bus.grant_id, 0);
    drive(4'b1111, 1'b0);
    drive(4'b1111, 1'b0);
    bus.lock = 1'b0;
    drive(4'b0000, 1'b0);
    check("t6_unlock_rotate", bus.grant_id, 1);
    drive(4'b0000, 1'b0);
    check("t6_idle", bus.grant, 0);
    check("t6_q_empty", exp_q.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule : tb_fifo_write_arbiter
`default_nettype wire
